// File: rtl/alu_step_sequencer.sv
// Cycle-exact controller that steps a loadable program of ROM address triples through
// the ROM/MUX/ALU32 datapath and hands each settled result to a valid/ready consumer.
module alu_step_sequencer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [8:0]                 prog_data,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic                       start,
  input  logic                       abort,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 rom_a_addr,
  output logic [1:0]                 rom_b_addr,
  output logic [4:0]                 rom_c_addr,
  input  logic [31:0]                alu_result,
  input  logic                       alu_cout,
  input  logic                       alu_ovf,
  input  logic                       alu_zero,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [31:0]                res_data,
  output logic [2:0]                 res_flags,
  output logic [$clog2(DEPTH)-1:0]   res_step
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef struct packed {
    logic [1:0] a_addr;
    logic [1:0] b_addr;
    logic [4:0] ctl_addr;
  } entry_t;

  logic [1:0]    state_q,     state_d;
  entry_t        prog_q [DEPTH];
  entry_t        prog_d [DEPTH];
  logic [LW-1:0] len_q,       len_d;
  logic [AW-1:0] step_q,      step_d;
  logic [CW-1:0] cnt_q,       cnt_d;
  logic          busy_q,      busy_d;
  logic          done_q,      done_d;
  logic [1:0]    a_q,         a_d;
  logic [1:0]    b_q,         b_d;
  logic [4:0]    c_q,         c_d;
  logic          res_valid_q, res_valid_d;
  logic [31:0]   res_data_q,  res_data_d;
  logic [2:0]    res_flags_q, res_flags_d;
  logic [AW-1:0] res_step_q,  res_step_d;

  logic [AW-1:0] step_inc;
  logic [LW-1:0] len_clip;
  logic          last_step;
  logic          cnt_last;
  entry_t        first_e;
  entry_t        next_e;

  assign step_inc  = step_q + AW'(1);
  assign len_clip  = (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
  assign last_step = (LW'(step_q) == (len_q - LW'(1)));
  assign cnt_last  = (cnt_q == CW'(SETTLE - 1));
  assign first_e   = prog_q[0];
  assign next_e    = prog_q[step_inc];

  // Program store: writes land only while idle, including the start edge.
  always_comb begin
    prog_d = prog_q;
    if (prog_we && (state_q == ST_IDLE)) begin
      prog_d[prog_addr] = entry_t'(prog_data);
    end
  end

  // Next-state and registered-output logic; abort overrides every other transition.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_step_d  = res_step_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            busy_d = 1'b1;
            if (prog_len == LW'(0)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_SETTLE;
              len_d   = len_clip;
              step_d  = AW'(0);
              cnt_d   = CW'(0);
              a_d     = first_e.a_addr;
              b_d     = first_e.b_addr;
              c_d     = first_e.ctl_addr;
            end
          end
        end

        ST_SETTLE: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_last) begin
            state_d     = ST_WAIT;
            res_valid_d = 1'b1;
            res_data_d  = alu_result;
            res_flags_d = {alu_cout, alu_ovf, alu_zero};
            res_step_d  = step_q;
          end
        end

        ST_WAIT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            if (last_step) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_SETTLE;
              step_d  = step_inc;
              cnt_d   = CW'(0);
              a_d     = next_e.a_addr;
              b_d     = next_e.b_addr;
              c_d     = next_e.ctl_addr;
            end
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end

        default: begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      step_q      <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_step_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        prog_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_step_q  <= res_step_d;
      prog_q      <= prog_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign rom_a_addr = a_q;
  assign rom_b_addr = b_q;
  assign rom_c_addr = c_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_flags  = res_flags_q;
  assign res_step   = res_step_q;

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Bench for alu_step_sequencer: the ALU returns its own address triple as the result, so each
// expected result is simply the program word stored for that step.
module tb_alu_step_sequencer;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [8:0]  prog_data;
  logic [3:0]  prog_len;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  rom_a_addr;
  logic [1:0]  rom_b_addr;
  logic [4:0]  rom_c_addr;
  logic [31:0] alu_result;
  logic        alu_cout;
  logic        alu_ovf;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [2:0]  res_flags;
  logic [2:0]  res_step;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [8:0] prog_m [DEPTH];

  alu_step_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
    .busy(busy), .done(done), .rom_a_addr(rom_a_addr), .rom_b_addr(rom_b_addr),
    .rom_c_addr(rom_c_addr), .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_ovf(alu_ovf), .alu_zero(alu_zero), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags),
    .res_step(res_step)
  );

  // Datapath stand-in: result echoes the addresses, flags are simple functions of them.
  assign alu_result = {23'b0, rom_a_addr, rom_b_addr, rom_c_addr};
  assign alu_cout   = rom_a_addr[0] ^ rom_c_addr[4];
  assign alu_ovf    = rom_b_addr[1];
  assign alu_zero   = (rom_c_addr == 5'd0);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_flags(input logic [8:0] w);
    return {w[7] ^ w[4], w[6], (w[4:0] == 5'd0)};
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_addr"},  32'({rom_a_addr, rom_b_addr, rom_c_addr}), 32'd0);
    chk({tag, "_data"},  res_data, 32'd0);
    chk({tag, "_flags"}, 32'(res_flags), 32'd0);
    chk({tag, "_step"},  32'(res_step), 32'd0);
  endtask

  task automatic wr(input int idx, input logic [8:0] data);
    prog_we   = 1'b1;
    prog_addr = 3'(idx);
    prog_data = data;
    tick();
    prog_we   = 1'b0;
    prog_m[idx] = data;
  endtask

  // hold_mode: 0 = ready held high, >0 = ready low that many cycles, <0 = random hold.
  task automatic run_check(input int len, input int hold_mode, input bit wr_busy, input bit wr_start);
    logic [8:0] snap [DEPTH];
    logic [8:0] w;
    logic [8:0] nd;
    int n, hold, e_cyc, load_cyc;
    n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
    for (int i = 0; i < int'(DEPTH); i++) snap[i] = prog_m[i];
    res_ready = (hold_mode == 0);
    prog_len  = 4'(len);
    start     = 1'b1;
    if (wr_start) begin
      nd        = 9'($urandom);
      prog_we   = 1'b1;
      prog_addr = 3'd0;
      prog_data = nd;
      prog_m[0] = nd;
    end
    tick();
    start   = 1'b0;
    prog_we = 1'b0;
    e_cyc    = cyc;
    load_cyc = cyc;
    chk("busy_at_start", 32'(busy), 32'd1);
    if (n == 0) begin
      chk("done_len0", 32'(done), 32'd1);
      chk("valid_len0", 32'(res_valid), 32'd0);
      tick();
      chk("busy_len0_end", 32'(busy), 32'd0);
      chk("done_len0_end", 32'(done), 32'd0);
      chk("valid_len0_end", 32'(res_valid), 32'd0);
      return;
    end
    for (int k = 0; k < n; k++) begin
      w = snap[k];
      chk("addr_a", 32'(rom_a_addr), 32'(w[8:7]));
      chk("addr_b", 32'(rom_b_addr), 32'(w[6:5]));
      chk("addr_c", 32'(rom_c_addr), 32'(w[4:0]));
      chk("valid_low_at_load", 32'(res_valid), 32'd0);
      chk("done_low_in_run", 32'(done), 32'd0);
      if (wr_busy && k == 1) begin
        prog_we   = 1'b1;
        prog_addr = 3'd3;
        prog_data = ~snap[3];
      end
      for (int s = 1; s < int'(SETTLE); s++) begin
        tick();
        prog_we = 1'b0;
        chk("valid_in_settle", 32'(res_valid), 32'd0);
        chk("addr_settle_hold", 32'(rom_c_addr), 32'(w[4:0]));
      end
      tick();
      prog_we = 1'b0;
      chk("valid_rise", 32'(res_valid), 32'd1);
      chk("settle_time", 32'(cyc - load_cyc), 32'(SETTLE));
      chk("res_data", res_data, {23'b0, w});
      chk("res_flags", 32'(res_flags), 32'(exp_flags(w)));
      chk("res_step", 32'(res_step), 32'(k));
      if (hold_mode == 0) chk("valid_rise_abs", 32'(cyc - e_cyc), 32'(k * (int'(SETTLE) + 1) + int'(SETTLE)));
      hold = (hold_mode < 0) ? int'($urandom_range(0, 3)) : hold_mode;
      if (hold_mode != 0) res_ready = (hold == 0);
      for (int h = 0; h < hold; h++) begin
        if (hold_mode < 0) start = 1'($urandom_range(0, 1));
        tick();
        chk("valid_hold", 32'(res_valid), 32'd1);
        chk("data_hold", res_data, {23'b0, w});
        chk("addr_hold", 32'({rom_a_addr, rom_b_addr, rom_c_addr}), 32'(w));
        chk("busy_hold", 32'(busy), 32'd1);
        if (h == hold - 1) begin
          res_ready = 1'b1;
          start     = 1'b0;
        end
      end
      tick();
      load_cyc = cyc;
      if (hold_mode != 0) res_ready = 1'b0;
      chk("valid_drop", 32'(res_valid), 32'd0);
      chk("done_at_handshake", 32'(done), 32'(k == n - 1));
      chk("busy_at_handshake", 32'(busy), 32'd1);
    end
    if (hold_mode == 0) chk("run_length", 32'(cyc - e_cyc), 32'(n * (int'(SETTLE) + 1)));
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("valid_end", 32'(res_valid), 32'd0);
    chk("addr_retained", 32'(rom_c_addr), 32'(snap[n - 1][4:0]));
  endtask

  initial begin
    rst_n = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) prog_m[i] = '0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    wr(0, 9'h021); wr(1, 9'h048); wr(2, 9'h169);
    wr(3, 9'h190); wr(4, 9'h177); wr(5, 9'h0FE);
    wr(6, 9'($urandom)); wr(7, 9'($urandom));

    run_check(6, 0, 1'b0, 1'b0);
    run_check(6, 5, 1'b0, 1'b0);
    run_check(0, 0, 1'b0, 1'b0);
    run_check(12, 0, 1'b0, 1'b0);

    // Abort during the settle of step 2, then a fresh run restarts at step 0.
    res_ready = 1'b1; prog_len = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("abort_pre_addr", 32'(rom_c_addr), 32'(prog_m[2][4:0]));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_addr_kept", 32'(rom_c_addr), 32'(prog_m[2][4:0]));
    chk("abort_step_kept", 32'(res_step), 32'd1);
    chk("abort_data_kept", res_data, {23'b0, prog_m[1]});
    tick();
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    run_check(6, 0, 1'b0, 1'b0);

    // start together with abort in idle is ignored.
    start = 1'b1; abort = 1'b1; prog_len = 4'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    tick();
    chk("start_abort_valid", 32'(res_valid), 32'd0);

    run_check(6, 0, 1'b1, 1'b0);
    run_check(6, 0, 1'b0, 1'b0);
    run_check(6, 0, 1'b0, 1'b1);
    run_check(6, -1, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      wr(int'($urandom_range(0, 7)), 9'($urandom));
      wr(int'($urandom_range(0, 7)), 9'($urandom));
      run_check(int'($urandom_range(0, 15)), -1, 1'b0, 1'b0);
    end

    // Reset mid-run clears outputs without a clock edge and wipes the program.
    res_ready = 1'b1; prog_len = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrun_reset");
    for (int i = 0; i < int'(DEPTH); i++) prog_m[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_check(1, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
